// File: rtl/l2_mem_pkg.sv
// Shared constants and encodings for the L2 memory-side line responder.
package l2_mem_pkg;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/mem_line_ram.sv
// Single-port line store: synchronous write, registered read-first output.
module mem_line_ram #(
    parameter int IDX_W  = 10,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<IDX_W)-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/l2_mem_responder.sv
// Fixed-latency memory responder for the L2 line interface: one line read or
// write per transaction, answered with a single-cycle mem_ready pulse.
module l2_mem_responder #(
    parameter int ADDR_W  = l2_mem_pkg::ADDR_W,
    parameter int DATA_W  = l2_mem_pkg::DATA_W,
    parameter int IDX_W   = 10,
    parameter int LATENCY = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              proto_err,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt
);

    import l2_mem_pkg::*;

    localparam logic [7:0] LAST_CNT = 8'(LATENCY - 1);

    state_t             r_state;
    op_t                r_op;
    logic [IDX_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_wdata;
    logic [7:0]         r_cnt;
    logic               r_ready;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_proto_err;
    logic [15:0]        r_rd_cnt;
    logic [15:0]        r_wr_cnt;

    logic               w_hold;
    logic [IDX_W-1:0]   w_ram_idx;
    logic               w_ram_we;
    logic [DATA_W-1:0]  w_ram_q;
    logic               w_unused_addr;

    // Upper address bits alias onto the same line.
    assign w_unused_addr = ^mem_addr[ADDR_W-1:IDX_W];

    // The captured op's own request line must stay high through BUSY.
    assign w_hold = (r_op == OP_WR) ? mem_write : mem_read;

    // In IDLE the RAM already looks up the incoming index so its output is
    // valid by the BUSY->RESP edge even at LATENCY=1.
    assign w_ram_idx = (r_state == IDLE) ? mem_addr[IDX_W-1:0] : r_idx;
    assign w_ram_we  = (r_state == RESP) && (r_op == OP_WR);

    mem_line_ram #(
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= OP_RD;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_ready     <= 1'b0;
            r_rdata     <= '0;
            r_proto_err <= 1'b0;
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b0;
                    r_rdata <= '0;
                    if (mem_read || mem_write) begin
                        r_op    <= mem_write ? OP_WR : OP_RD;
                        r_idx   <= mem_addr[IDX_W-1:0];
                        r_wdata <= mem_wdata;
                        r_cnt   <= '0;
                        r_state <= BUSY;
                        if (mem_read && mem_write) begin
                            r_proto_err <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (!w_hold) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == LAST_CNT) begin
                            r_state <= RESP;
                            r_ready <= 1'b1;
                            if (r_op == OP_RD) begin
                                r_rdata <= w_ram_q;
                            end
                        end
                    end
                end
                RESP: begin
                    r_ready <= 1'b0;
                    r_rdata <= '0;
                    r_state <= IDLE;
                    if (r_op == OP_RD) begin
                        if (r_rd_cnt != 16'hFFFF) begin
                            r_rd_cnt <= r_rd_cnt + 16'd1;
                        end
                    end else begin
                        if (r_wr_cnt != 16'hFFFF) begin
                            r_wr_cnt <= r_wr_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_rdata <= '0;
                end
            endcase
        end
    end

    assign mem_rdata = r_rdata;
    assign mem_ready = r_ready;
    assign proto_err = r_proto_err;
    assign rd_cnt    = r_rd_cnt;
    assign wr_cnt    = r_wr_cnt;

endmodule

// File: tb/tb_l2_mem_responder.sv
// Randomized self-checking bench for l2_mem_responder against a line-store model.
module tb_l2_mem_responder;

    localparam int LAT     = 8;
    localparam int EXP_LAT = LAT + 1;

    logic         clk;
    logic         rst_n;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         proto_err;
    logic [15:0]  rd_cnt;
    logic [15:0]  wr_cnt;

    int vectors     = 0;
    int miscompares = 0;

    logic [127:0] model_mem [int];
    int           model_rd   = 0;
    int           model_wr   = 0;
    bit           model_perr = 1'b0;

    l2_mem_responder #(
        .ADDR_W  (28),
        .DATA_W  (128),
        .IDX_W   (10),
        .LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .proto_err (proto_err),
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int idx_of(input logic [27:0] a);
        return int'(a) % 1024;
    endfunction

    function automatic logic [127:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drive(input bit rd, input bit wr, input logic [27:0] a, input logic [127:0] d);
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = a;
        mem_wdata = d;
    endtask

    // Counts falling edges until mem_ready; mem_rdata must stay 0 meanwhile.
    task automatic wait_ready(output int cyc);
        bit got;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (mem_ready === 1'b1) begin
                got = 1'b1;
            end else begin
                vectors++;
                if (mem_rdata !== 128'h0) begin
                    $display("FAIL rdata_idle: got %h need 0 (cycle %0d)", mem_rdata, cyc);
                    miscompares++;
                end
            end
        end
        if (!got) begin
            $display("FAIL ready_timeout: no mem_ready within %0d cycles", cyc);
            miscompares++;
        end
    endtask

    task automatic end_txn();
        drive(1'b0, 1'b0, 28'h0, 128'h0);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 28'h0, 128'h0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({mem_ready, proto_err, rd_cnt, wr_cnt, mem_rdata} !== '0) begin
            $display("FAIL reset_outputs: ready=%b perr=%b rd=%0d wr=%0d rdata=%h need all 0",
                     mem_ready, proto_err, rd_cnt, wr_cnt, mem_rdata);
            miscompares++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (mem_ready !== 1'b0 || rd_cnt !== 16'd0) begin
            $display("FAIL post_reset: ready=%b rd=%0d need 0 0", mem_ready, rd_cnt);
            miscompares++;
        end
    endtask

    task automatic test_read_latency();
        int cyc;
        logic [127:0] d;
        d = 128'h0123456789ABCDEF0123456789ABCDEF;
        drive(1'b0, 1'b1, 28'h0000005, d);
        wait_ready(cyc);
        model_mem[5] = d;
        model_wr++;
        end_txn();
        drive(1'b1, 1'b0, 28'h0000005, rand_line());
        wait_ready(cyc);
        vectors++;
        if (cyc != EXP_LAT) begin
            $display("FAIL read_latency: got %0d cycles need %0d", cyc, EXP_LAT);
            miscompares++;
        end
        vectors++;
        if (mem_rdata !== model_mem[5]) begin
            $display("FAIL read_data: got %h need %h", mem_rdata, model_mem[5]);
            miscompares++;
        end
        model_rd++;
        end_txn();
        vectors++;
        if (mem_ready !== 1'b0 || mem_rdata !== 128'h0) begin
            $display("FAIL ready_pulse: ready=%b rdata=%h need 0 0", mem_ready, mem_rdata);
            miscompares++;
        end
        vectors++;
        if (rd_cnt !== 16'(model_rd) || wr_cnt !== 16'(model_wr)) begin
            $display("FAIL counts_a: rd=%0d wr=%0d need %0d %0d", rd_cnt, wr_cnt, model_rd, model_wr);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back(input logic [27:0] wa, input logic [27:0] ra);
        int cyc;
        logic [127:0] d;
        d = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF ^ {96'h0, $urandom()};
        drive(1'b0, 1'b1, wa, d);
        wait_ready(cyc);
        vectors++;
        if (cyc != EXP_LAT || mem_rdata !== 128'h0) begin
            $display("FAIL b2b_write: cycles %0d rdata %h need %0d and 0", cyc, mem_rdata, EXP_LAT);
            miscompares++;
        end
        model_mem[idx_of(wa)] = d;
        model_wr++;
        // Switch to the read in the ready cycle; one idle cycle precedes capture.
        drive(1'b1, 1'b0, ra, 128'h0);
        wait_ready(cyc);
        vectors++;
        if (cyc != EXP_LAT + 1) begin
            $display("FAIL b2b_latency: got %0d cycles need %0d", cyc, EXP_LAT + 1);
            miscompares++;
        end
        vectors++;
        if (mem_rdata !== model_mem[idx_of(ra)]) begin
            $display("FAIL b2b_data: got %h need %h", mem_rdata, model_mem[idx_of(ra)]);
            miscompares++;
        end
        model_rd++;
        end_txn();
        vectors++;
        if (rd_cnt !== 16'(model_rd) || wr_cnt !== 16'(model_wr)) begin
            $display("FAIL counts_b2b: rd=%0d wr=%0d need %0d %0d", rd_cnt, wr_cnt, model_rd, model_wr);
            miscompares++;
        end
    endtask

    task automatic test_wb_alloc();
        int cyc;
        logic [127:0] d;
        d = rand_line();
        drive(1'b0, 1'b1, 28'h0000120, d);
        wait_ready(cyc);
        model_mem[idx_of(28'h0000120)] = d;
        model_wr++;
        end_txn();
        test_back_to_back(28'h0000020, 28'h0000120);
        drive(1'b1, 1'b0, 28'h0000020, 128'h0);
        wait_ready(cyc);
        vectors++;
        if (mem_rdata !== model_mem[idx_of(28'h0000020)]) begin
            $display("FAIL wb_line: got %h need %h", mem_rdata, model_mem[idx_of(28'h0000020)]);
            miscompares++;
        end
        model_rd++;
        end_txn();
    endtask

    task automatic test_abort();
        int cyc;
        drive(1'b1, 1'b0, 28'h0000005, 128'h0);
        repeat (3) @(negedge clk);
        drive(1'b0, 1'b0, 28'h0, 128'h0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            vectors++;
            if (mem_ready !== 1'b0) begin
                $display("FAIL abort_ready: mem_ready=%b at cycle %0d need 0", mem_ready, i);
                miscompares++;
            end
        end
        vectors++;
        if (rd_cnt !== 16'(model_rd)) begin
            $display("FAIL abort_count: rd=%0d need %0d", rd_cnt, model_rd);
            miscompares++;
        end
        drive(1'b1, 1'b0, 28'h0000005, 128'h0);
        wait_ready(cyc);
        vectors++;
        if (cyc != EXP_LAT || mem_rdata !== model_mem[5]) begin
            $display("FAIL after_abort: cycles %0d data %h need %0d %h", cyc, mem_rdata, EXP_LAT, model_mem[5]);
            miscompares++;
        end
        model_rd++;
        end_txn();
    endtask

    task automatic test_proto_err();
        int cyc;
        logic [127:0] d;
        d = rand_line();
        drive(1'b1, 1'b1, 28'h0000007, d);
        wait_ready(cyc);
        model_mem[7] = d;
        model_wr++;
        model_perr = 1'b1;
        vectors++;
        if (proto_err !== model_perr || mem_rdata !== 128'h0) begin
            $display("FAIL proto_set: perr=%b rdata=%h need 1 and 0", proto_err, mem_rdata);
            miscompares++;
        end
        end_txn();
        vectors++;
        if (wr_cnt !== 16'(model_wr) || rd_cnt !== 16'(model_rd)) begin
            $display("FAIL proto_count: wr=%0d rd=%0d need %0d %0d", wr_cnt, rd_cnt, model_wr, model_rd);
            miscompares++;
        end
        drive(1'b1, 1'b0, 28'h0000007, 128'h0);
        wait_ready(cyc);
        vectors++;
        if (mem_rdata !== model_mem[7] || proto_err !== model_perr) begin
            $display("FAIL proto_readback: data %h perr %b need %h %b", mem_rdata, proto_err, model_mem[7], model_perr);
            miscompares++;
        end
        model_rd++;
        end_txn();
    endtask

    task automatic test_random();
        int cyc;
        int idx;
        bit rd;
        bit in_resp;
        logic [27:0] a;
        logic [127:0] d;
        in_resp = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (in_resp && $urandom_range(0, 1) == 0) begin
                drive(1'b0, 1'b0, 28'h0, 128'h0);
                @(negedge clk);
                in_resp = 1'b0;
            end
            idx = int'($urandom_range(0, 15));
            a = 28'($urandom()) & 28'hFFFFC00 | 28'(idx);
            rd = ($urandom_range(0, 1) == 1) && model_mem.exists(idx);
            d = rand_line();
            drive(rd, !rd, a, d);
            wait_ready(cyc);
            vectors++;
            if (cyc != (in_resp ? EXP_LAT + 1 : EXP_LAT)) begin
                $display("FAIL rand_latency: txn %0d got %0d cycles", n, cyc);
                miscompares++;
            end
            if (rd) begin
                vectors++;
                if (mem_rdata !== model_mem[idx]) begin
                    $display("FAIL rand_read: txn %0d idx %0d got %h need %h", n, idx, mem_rdata, model_mem[idx]);
                    miscompares++;
                end
                model_rd++;
            end else begin
                model_mem[idx] = d;
                model_wr++;
            end
            in_resp = 1'b1;
        end
        end_txn();
        vectors++;
        if (rd_cnt !== 16'(model_rd) || wr_cnt !== 16'(model_wr)) begin
            $display("FAIL rand_counts: rd=%0d wr=%0d need %0d %0d", rd_cnt, wr_cnt, model_rd, model_wr);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        drive(1'b0, 1'b1, 28'h0000005, rand_line());
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_rd   = 0;
        model_wr   = 0;
        model_perr = 1'b0;
        vectors++;
        if ({mem_ready, proto_err, rd_cnt, wr_cnt, mem_rdata} !== '0) begin
            $display("FAIL midreset_outputs: ready=%b perr=%b rd=%0d wr=%0d need all 0",
                     mem_ready, proto_err, rd_cnt, wr_cnt);
            miscompares++;
        end
        drive(1'b0, 1'b0, 28'h0, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b1, 1'b0, 28'h0000005, 128'h0);
        wait_ready(cyc);
        vectors++;
        if (mem_rdata !== model_mem[5]) begin
            $display("FAIL midreset_line: got %h need %h", mem_rdata, model_mem[5]);
            miscompares++;
        end
        model_rd++;
        end_txn();
        vectors++;
        if (rd_cnt !== 16'(model_rd) || wr_cnt !== 16'(model_wr) || proto_err !== model_perr) begin
            $display("FAIL midreset_counts: rd=%0d wr=%0d perr=%b need %0d %0d %b",
                     rd_cnt, wr_cnt, proto_err, model_rd, model_wr, model_perr);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_back_to_back(28'h0000010, 28'h0000010);
        test_wb_alloc();
        test_abort();
        test_proto_err();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
